// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared sizes and records for the CDB writeback arbiter.
//   NUM_FU / NUM_CDB / NUM_PR : machine sizing
//   FU_RESULT_ENTRY_t         : per-FU result record presented to the arbiter
//   CDB_ENTRY_t               : one registered CDB broadcast slot
package cdb_arbiter_pkg;
    localparam int NUM_FU  = 4;
    localparam int NUM_CDB = 2;
    localparam int NUM_PR  = 64;
    localparam int PR_W    = $clog2(NUM_PR);
    localparam int XLEN    = 64;

    typedef struct packed {
        logic            done;
        logic [PR_W-1:0] T_idx;
        logic [XLEN-1:0] result;
    } FU_RESULT_ENTRY_t;

    typedef struct packed {
        logic            valid;
        logic [PR_W-1:0] T_idx;
        logic [XLEN-1:0] result;
    } CDB_ENTRY_t;
endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// rr_select: combinational rotating multi-grant finder.
//   req        : request vector, one bit per FU
//   ptr        : scan start index
//   gnt        : first M requesters in scan order ptr, ptr+1, ... (mod N)
//   slot       : slot index assigned to each granted requester
//   any_deny   : at least one requester was left without a slot
//   first_deny : first denied requester in scan order (ptr when none)
module rr_select #(
    parameter int N      = 4,
    parameter int M      = 2,
    parameter int PTR_W  = 2,
    parameter int SLOT_W = 1
) (
    input  logic [N-1:0]             req,
    input  logic [PTR_W-1:0]         ptr,
    output logic [N-1:0]             gnt,
    output logic [N-1:0][SLOT_W-1:0] slot,
    output logic                     any_deny,
    output logic [PTR_W-1:0]         first_deny
);
    logic [PTR_W-1:0] idx;
    int               cnt;

    always_comb begin
        gnt        = '0;
        slot       = '0;
        any_deny   = 1'b0;
        first_deny = ptr;
        idx        = '0;
        cnt        = 0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                if (cnt < M) begin
                    gnt[idx]  = 1'b1;
                    slot[idx] = SLOT_W'(cnt);
                    cnt       = cnt + 1;
                end else if (!any_deny) begin
                    any_deny   = 1'b1;
                    first_deny = idx;
                end
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin scheduler of NUM_FU result ports onto NUM_CDB
// registered common-data-bus slots.
//   clock, reset(sync, active low), rollback : control
//   fu_done / fu_T_idx / fu_result           : per-FU results this cycle
//   full_hazard                              : done but not granted -> FU holds
//   cdb_valid / cdb_T_idx / cdb_result       : registered broadcasts (latency 1)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU  = cdb_arbiter_pkg::NUM_FU,
    parameter int NUM_CDB = cdb_arbiter_pkg::NUM_CDB,
    parameter int PR_W    = cdb_arbiter_pkg::PR_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             rollback,
    input  logic [NUM_FU-1:0]                fu_done,
    input  logic [NUM_FU-1:0][PR_W-1:0]      fu_T_idx,
    input  logic [NUM_FU-1:0][63:0]          fu_result,
    output logic [NUM_FU-1:0]                full_hazard,
    output logic [NUM_CDB-1:0]               cdb_valid,
    output logic [NUM_CDB-1:0][PR_W-1:0]     cdb_T_idx,
    output logic [NUM_CDB-1:0][63:0]         cdb_result
);
    localparam int PTR_W  = (NUM_FU  > 1) ? $clog2(NUM_FU)  : 1;
    localparam int SLOT_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    FU_RESULT_ENTRY_t [NUM_FU-1:0]   fu_in;
    logic [NUM_FU-1:0]               req;
    logic [NUM_FU-1:0]               gnt;
    logic [NUM_FU-1:0][SLOT_W-1:0]   slot;
    logic                            any_deny;
    logic [PTR_W-1:0]                first_deny;

    logic [PTR_W-1:0]                ptr_q, ptr_d;
    CDB_ENTRY_t [NUM_CDB-1:0]        cdb_q, cdb_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_in[i] = '{done: fu_done[i], T_idx: fu_T_idx[i], result: fu_result[i]};
        // Rollback removes every request, so nothing is granted or denied
        // and the pointer stays put.
        assign req[i]   = fu_in[i].done & ~rollback;
    end

    rr_select #(
        .N      (NUM_FU),
        .M      (NUM_CDB),
        .PTR_W  (PTR_W),
        .SLOT_W (SLOT_W)
    ) u_sel (
        .req        (req),
        .ptr        (ptr_q),
        .gnt        (gnt),
        .slot       (slot),
        .any_deny   (any_deny),
        .first_deny (first_deny)
    );

    assign full_hazard = req & ~gnt & {NUM_FU{reset}};

    // Slot k takes the single granted FU whose slot index is k.
    always_comb begin
        cdb_d = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (gnt[i] && slot[i] == SLOT_W'(k)) begin
                    cdb_d[k] = '{valid: 1'b1, T_idx: fu_in[i].T_idx, result: fu_in[i].result};
                end
            end
        end
    end

    // Priority moves to the first loser so it is served first next cycle.
    always_comb begin
        ptr_d = any_deny ? first_deny : ptr_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q <= '0;
            cdb_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cdb_q <= cdb_d;
        end
    end

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_out
        assign cdb_valid[k]  = cdb_q[k].valid;
        assign cdb_T_idx[k]  = cdb_q[k].T_idx;
        assign cdb_result[k] = cdb_q[k].result;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin writeback scheduler that shares `NUM_CDB` common-data-bus slots among the `NUM_FU` functional-unit result ports (ALUs, pipelined multipliers). It sits between the FU result outputs and the CDB broadcast registers. Each cycle it grants up to `NUM_CDB` finished FUs and registers their results onto the CDB. It asserts `full_hazard` to every finished FU it could not grant, which stalls that FU in place.

## Interface
Parameters:
- `NUM_FU`, 4: number of FU result ports.
- `NUM_CDB`, 2: CDB slots per cycle; 1 ≤ `NUM_CDB` ≤ `NUM_FU`.
- `PR_W`, `$clog2(NUM_PR)` (6): physical-register tag width.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `rollback`  in  1  squash: no grants this cycle.
- `fu_done`  in  `NUM_FU`  FU i has a valid result this cycle.
- `fu_T_idx`  in  `NUM_FU`×`PR_W`  destination tag per FU.
- `fu_result`  in  `NUM_FU`×64  result value per FU.
- `full_hazard`  out  `NUM_FU`  FU i done but not granted; FU i must hold its output.
- `cdb_valid`  out  `NUM_CDB`  slot k carries a broadcast.
- `cdb_T_idx`  out  `NUM_CDB`×`PR_W`  broadcast tag per slot.
- `cdb_result`  out  `NUM_CDB`×64  broadcast value per slot.

## Operation
- State consists of the priority pointer `ptr` (`$clog2(NUM_FU)` bits) and the CDB output registers.
- Scan order: FU `ptr`, `ptr+1`, …, wrapping modulo `NUM_FU`.
- Grants go to the first `NUM_CDB` FUs in scan order with `fu_done`=1. The j-th granted FU fills slot j. Unfilled slots are invalid.
- `full_hazard[i]` = `fu_done[i]` & !granted[i] & !`rollback`. This output is combinational in the same cycle.
- Pointer update:
  - If any FU was denied, `ptr` ← index of the first denied FU in scan order.
  - Otherwise `ptr` is unchanged.
- Starvation bound: a continuously requesting FU is granted within ⌈`NUM_FU`/`NUM_CDB`⌉ cycles of its first request.
- A denied FU re-presents identical `T_idx`/result on following cycles. The arbiter keeps no copy of denied data.
- `rollback`=1:
  - Zero grants.
  - `full_hazard` all 0, because the FUs are being flushed.
  - Next cycle `cdb_valid` is all 0.
  - `ptr` is unchanged.
- `NUM_CDB` = `NUM_FU`: every done FU is granted and `full_hazard` is constantly 0.
- Tag and value are passed through unmodified at 64-bit width. There is no arithmetic on data.
- Reset (`reset`=0 at posedge):
  - `ptr`=0.
  - `cdb_valid`=0, `cdb_T_idx`=0, `cdb_result`=0.
  - `full_hazard` is forced to 0 while `reset`=0.
  - Reset overrides `rollback` and any in-flight grant.

## Timing
- Grant decision is combinational in cycle N. The CDB output is registered and visible in cycle N+1 (latency 1).
- `full_hazard` is valid in cycle N, in time for the FU's stage registers at the N+1 edge.
- Throughput: up to `NUM_CDB` results per cycle, back-to-back, with no bubble between grants.
- A result denied in N and granted in N+1 appears on the CDB in N+2.
- Reset mid-operation: outputs are cleared at the first posedge with `reset`=0. Granted-but-unbroadcast results are dropped.

## Structure
- Shared package holds:
  - `CDB_ENTRY_t` {valid, T_idx[`PR_W`], result[64]}.
  - `NUM_CDB` alongside `NUM_FU`/`NUM_PR`.
  - Existing `FU_RESULT_ENTRY_t` as the per-FU input record.
- One sub-module, `rr_select`: purely combinational rotating multi-grant finder. Inputs are the request vector and `ptr`. Outputs are the grant vector, slot index per grant, and first-denied index.
- The top level holds the `ptr` register, the output registers, the hazard logic and the slot muxes.

## Test plan
1. Reset: hold `reset`=0 for 2 cycles with all `fu_done`=1 → `cdb_valid`=0, `full_hazard`=0, `ptr`=0. After release, the first grants are FU0 and FU1.
2. Contention (`NUM_FU`=4, `NUM_CDB`=2, `ptr`=0, all done, tags 10/11/12/13):
   - Cycle N: `full_hazard`=4'b1100, `ptr`→2.
   - Cycle N+1: CDB carries tags 10 and 11, and FU2/FU3 are granted.
   - Cycle N+2: CDB carries tags 12 and 13.
3. Single requester: FU3 done, tag 5, result 0xDEAD → next cycle slot0 = {1, 5, 0xDEAD}, slot1 invalid, no hazard, `ptr` unchanged.
4. Wrap-around: `ptr`=3, FUs 0/1/3 done → FU3 takes slot0, FU0 takes slot1, `full_hazard`=4'b0010, `ptr`→1.
5. Rollback and reset precedence:
   - `rollback` with all done → `full_hazard`=0 and next-cycle `cdb_valid`=0.
   - `rollback`=1 together with `reset`=0 → reset values.
6. Random stress, 1000 cycles, with done held while hazarded. Check:
   - Every result is broadcast exactly once, in order per FU.
   - The starvation bound holds.
   - No slot is valid without a matching grant.
